// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: XNOR tap masks, checker lock states, bit popcount.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int POP_W = 7;

    // Bit (t-1) set for tap t; maximal-length XNOR polynomials for 3..32 stages.
    function automatic logic [31:0] tap_mask(input int n);
        logic [31:0] m;
        case (n)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [63:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_word_step.sv
// Unrolled DATA_W-step XNOR Fibonacci LFSR advance, MSB of bits_out produced first.
// Latency: combinational.
// Backpressure: none; self_feed=1 shifts in predictions (generator), 0 shifts in data_in (checker).
module prbs_word_step
    import prbs_pkg::*;
#(
    parameter int NUM_BITS = 31,
    parameter int DATA_W   = 8
) (
    input  logic [NUM_BITS-1:0] state_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                self_feed,
    output logic [NUM_BITS-1:0] state_out,
    output logic [DATA_W-1:0]   bits_out
);

    localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(tap_mask(NUM_BITS));

    always_comb begin
        logic [NUM_BITS-1:0] s;
        logic                nb;
        s        = state_in;
        nb       = 1'b0;
        bits_out = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            nb          = ~^(s & TAPS);
            bits_out[i] = nb;
            s           = {s[NUM_BITS-2:0], (self_feed ? nb : data_in[i])};
        end
        state_out = s;
    end

endmodule

// File: rtl/prbs_gen_check.sv
// Multi-bit PRBS generator plus self-synchronising checker with lock FSM and error counter.
// Latency: generator word 1 clock after enable; checker flags/counts 1 clock after i_Chk_Valid.
// Backpressure: none; i_Enable stalls the generator, checker acts only on i_Chk_Valid. Option: PRBS_ERR_INJECT_EN.
module prbs_gen_check
    import prbs_pkg::*;
#(
    parameter int NUM_BITS     = 31,
    parameter int DATA_W       = 8,
    parameter int LOCK_WORDS   = 4,
    parameter int UNLOCK_WORDS = 4,
    parameter int CNT_W        = 32
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [DATA_W-1:0]   o_Data,
    output logic                o_Data_Valid,
    output logic                o_Wrap,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                i_Inj_Err,
`endif
    input  logic                i_Chk_Valid,
    input  logic [DATA_W-1:0]   i_Chk_Data,
    input  logic                i_Err_Clr,
    output logic                o_Locked,
    output logic                o_Err_Word,
    output logic [CNT_W-1:0]    o_Err_Count
);

    localparam logic [NUM_BITS-1:0] WRAP_LAST = {{(NUM_BITS-1){1'b1}}, 1'b0};
    localparam int RUN_MAX = (LOCK_WORDS > UNLOCK_WORDS) ? LOCK_WORDS : UNLOCK_WORDS;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    // ---------------- generator ----------------
    logic [NUM_BITS-1:0] gen_state;
    logic [NUM_BITS-1:0] gen_next;
    logic [NUM_BITS-1:0] seed_q;
    logic [NUM_BITS-1:0] seed_fix;
    logic [NUM_BITS-1:0] word_cnt;
    logic [DATA_W-1:0]   gen_bits;
    logic [DATA_W-1:0]   inj_mask;
    logic                wrap_hit;

    prbs_word_step #(
        .NUM_BITS (NUM_BITS),
        .DATA_W   (DATA_W)
    ) u_gen_step (
        .state_in  (gen_state),
        .data_in   ({DATA_W{1'b0}}),
        .self_feed (1'b1),
        .state_out (gen_next),
        .bits_out  (gen_bits)
    );

`ifdef PRBS_ERR_INJECT_EN
    assign inj_mask = DATA_W'(i_Inj_Err);
`else
    assign inj_mask = '0;
`endif

    // All-ones is the XNOR lock-up state, so it is never allowed into the LFSR.
    assign seed_fix = (&i_Seed_Data) ? '0 : i_Seed_Data;
    assign wrap_hit = (word_cnt == WRAP_LAST) && (gen_next == seed_q);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            gen_state    <= '0;
            seed_q       <= '0;
            word_cnt     <= '0;
            o_Data       <= '0;
            o_Data_Valid <= 1'b0;
            o_Wrap       <= 1'b0;
        end else if (i_Enable && i_Seed_DV) begin
            gen_state    <= seed_fix;
            seed_q       <= seed_fix;
            word_cnt     <= '0;
            o_Data_Valid <= 1'b0;
            o_Wrap       <= 1'b0;
        end else if (i_Enable) begin
            gen_state    <= gen_next;
            word_cnt     <= (word_cnt == WRAP_LAST) ? '0 : word_cnt + 1'b1;
            o_Data       <= gen_bits ^ inj_mask;
            o_Data_Valid <= 1'b1;
            o_Wrap       <= wrap_hit;
        end else begin
            o_Data_Valid <= 1'b0;
            o_Wrap       <= 1'b0;
        end
    end

    // ---------------- checker ----------------
    logic [NUM_BITS-1:0] hist;
    logic [NUM_BITS-1:0] hist_next;
    logic [DATA_W-1:0]   pred_bits;
    logic [POP_W-1:0]    chk_pop;
    logic                word_err;
    chk_state_t          fsm_q, fsm_d;
    logic [RUN_W-1:0]    clean_q, clean_d;
    logic [RUN_W-1:0]    err_q, err_d;
    logic                cnt_add;
    logic [SUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_sat;

    prbs_word_step #(
        .NUM_BITS (NUM_BITS),
        .DATA_W   (DATA_W)
    ) u_chk_step (
        .state_in  (hist),
        .data_in   (i_Chk_Data),
        .self_feed (1'b0),
        .state_out (hist_next),
        .bits_out  (pred_bits)
    );

    assign chk_pop  = popcount(64'(pred_bits ^ i_Chk_Data));
    assign word_err = (chk_pop != '0);
    assign cnt_sum  = SUM_W'(o_Err_Count) + SUM_W'(chk_pop);
    assign cnt_sat  = (cnt_sum > CNT_MAX) ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            fsm_q   <= SEARCH;
            clean_q <= '0;
            err_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            clean_q <= clean_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        clean_d = clean_q;
        err_d   = err_q;
        if (i_Chk_Valid) begin
            case (fsm_q)
                SEARCH: begin
                    if (word_err) begin
                        clean_d = '0;
                    end else begin
                        clean_d = clean_q + 1'b1;
                        if (clean_d == RUN_W'(LOCK_WORDS)) begin
                            fsm_d = LOCKED;
                            err_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (word_err) begin
                        err_d = err_q + 1'b1;
                        if (err_d == RUN_W'(UNLOCK_WORDS)) begin
                            fsm_d   = SEARCH;
                            clean_d = '0;
                        end
                    end else begin
                        err_d = '0;
                    end
                end
                default: fsm_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        o_Locked = (fsm_q == LOCKED);
        cnt_add  = i_Chk_Valid && word_err && (fsm_q == LOCKED);
    end

    // Clear takes priority over a same-cycle add.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hist        <= '0;
            o_Err_Word  <= 1'b0;
            o_Err_Count <= '0;
        end else begin
            o_Err_Word <= i_Chk_Valid && word_err;
            if (i_Chk_Valid) begin
                hist <= hist_next;
            end
            if (i_Err_Clr) begin
                o_Err_Count <= '0;
            end else if (cnt_add) begin
                o_Err_Count <= cnt_sat;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_check.sv
// Directed bench for prbs_gen_check at NUM_BITS=7, DATA_W=8, CNT_W=4.
// Generator vectors are hand-derived from x[t] = XNOR(x[t-7], x[t-6]).
module tb_prbs_gen_check;

    logic       i_Clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sdv = 1'b0;
    logic [6:0] seed = '0;
    logic       loop = 1'b0;
    logic [7:0] flip = '0;
    logic       chk_vld_drv = 1'b0;
    logic [7:0] chk_dat_drv = '0;
    logic       clr = 1'b0;

    logic       chk_vld;
    logic [7:0] chk_dat;
    logic [7:0] o_Data;
    logic       o_Data_Valid;
    logic       o_Wrap;
    logic       o_Locked;
    logic       o_Err_Word;
    logic [3:0] o_Err_Count;

    int checks = 0;
    int errors = 0;

    assign chk_vld = loop ? o_Data_Valid : chk_vld_drv;
    assign chk_dat = loop ? (o_Data ^ flip) : chk_dat_drv;

    always #5 i_Clk = ~i_Clk;

    prbs_gen_check #(
        .NUM_BITS     (7),
        .DATA_W       (8),
        .LOCK_WORDS   (4),
        .UNLOCK_WORDS (4),
        .CNT_W        (4)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (rst),
        .i_Enable     (en),
        .i_Seed_DV    (sdv),
        .i_Seed_Data  (seed),
        .o_Data       (o_Data),
        .o_Data_Valid (o_Data_Valid),
        .o_Wrap       (o_Wrap),
`ifdef PRBS_ERR_INJECT_EN
        .i_Inj_Err    (1'b0),
`endif
        .i_Chk_Valid  (chk_vld),
        .i_Chk_Data   (chk_dat),
        .i_Err_Clr    (clr),
        .o_Locked     (o_Locked),
        .o_Err_Word   (o_Err_Word),
        .o_Err_Count  (o_Err_Count)
    );

    typedef struct {
        logic       en;
        logic       sdv;
        logic [6:0] seed;
        logic [7:0] exp_dat;
        logic       exp_vld;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   32'(o_Data), 32'h0);
        check({tag, "_valid"},  32'(o_Data_Valid), 32'h0);
        check({tag, "_wrap"},   32'(o_Wrap), 32'h0);
        check({tag, "_locked"}, 32'(o_Locked), 32'h0);
        check({tag, "_errw"},   32'(o_Err_Word), 32'h0);
        check({tag, "_cnt"},    32'(o_Err_Count), 32'h0);
    endtask

    // Bit-serial reference: returns {next_state, word}, first bit in word[7].
    function automatic logic [14:0] model_word(input logic [6:0] st);
        logic [6:0] s;
        logic [7:0] w;
        logic       nb;
        s = st;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            nb   = ~(s[6] ^ s[5]);
            w[i] = nb;
            s    = {s[5:0], nb};
        end
        return {s, w};
    endfunction

    initial begin
        int         n;
        logic [6:0] mst;
        logic [14:0] mres;

        vecs[0]  = '{1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 7'h00, 8'hFD, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 7'h00, 8'hF3, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 7'h00, 8'hF3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 7'h00, 8'hD7, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 7'h7F, 8'hD7, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 7'h00, 8'hFD, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 7'h01, 8'hFD, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 7'h00, 8'hF3, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 7'h01, 8'hF3, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 7'h00, 8'hFB, 1'b1, 1'b0};

        // Reset values
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Generator vectors (checker idle)
        for (int i = 0; i < 11; i++) begin
            en   = vecs[i].en;
            sdv  = vecs[i].sdv;
            seed = vecs[i].seed;
            tick();
            check($sformatf("vec%0d_data", i), 32'(o_Data), 32'(vecs[i].exp_dat));
            check($sformatf("vec%0d_valid", i), 32'(o_Data_Valid), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_wrap", i), 32'(o_Wrap), 32'(vecs[i].exp_wrap));
        end
        en  = 1'b0;
        sdv = 1'b0;

        // Loopback from the reset state: word 1 is checked at edge 2, lock after word 4
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        en   = 1'b1;
        loop = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("lock_k%0d", k), 32'(o_Locked), (k >= 5) ? 32'h1 : 32'h0);
            check($sformatf("lock_cnt_k%0d", k), 32'(o_Err_Count), 32'h0);
            check($sformatf("lock_errw_k%0d", k), 32'(o_Err_Word), 32'h0);
        end

        // One flipped bit while locked: 1 mismatch now, 2 more as it passes taps 6 and 7
        flip = 8'h01;
        tick();
        flip = 8'h00;
        check("flip_errw1", 32'(o_Err_Word), 32'h1);
        check("flip_cnt1", 32'(o_Err_Count), 32'h1);
        tick();
        check("flip_errw2", 32'(o_Err_Word), 32'h1);
        check("flip_cnt2", 32'(o_Err_Count), 32'h3);
        check("flip_lock2", 32'(o_Locked), 32'h1);
        tick();
        check("flip_errw3", 32'(o_Err_Word), 32'h0);
        check("flip_cnt3", 32'(o_Err_Count), 32'h3);
        check("flip_lock3", 32'(o_Locked), 32'h1);

        // Constant zero words: every word errored, unlock after the 4th, count saturates
        loop        = 1'b0;
        chk_vld_drv = 1'b1;
        chk_dat_drv = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("zero_lock_k%0d", k), 32'(o_Locked), (k < 4) ? 32'h1 : 32'h0);
        end
        check("zero_cnt_sat", 32'(o_Err_Count), 32'hF);
        check("zero_errw", 32'(o_Err_Word), 32'h1);
        tick();
        tick();
        check("search_cnt_hold", 32'(o_Err_Count), 32'hF);
        check("search_unlocked", 32'(o_Locked), 32'h0);

        chk_vld_drv = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", 32'(o_Err_Count), 32'h0);
        chk_vld_drv = 1'b1;
        repeat (3) tick();
        check("search_no_add", 32'(o_Err_Count), 32'h0);
        check("search_errw", 32'(o_Err_Word), 32'h1);
        check("search_still", 32'(o_Locked), 32'h0);

        // Resume loopback: history resynchronises and the checker relocks
        chk_vld_drv = 1'b0;
        loop = 1'b1;
        n = 0;
        while (!o_Locked && n < 20) begin
            tick();
            n++;
        end
        check("relock", 32'(o_Locked), 32'h1);
        check("relock_cnt", 32'(o_Err_Count), 32'h0);
        tick();

        // Clear coinciding with an errored word wins; the follow-on word still adds
        flip = 8'h01;
        clr  = 1'b1;
        tick();
        flip = 8'h00;
        clr  = 1'b0;
        check("clrwin_cnt", 32'(o_Err_Count), 32'h0);
        check("clrwin_errw", 32'(o_Err_Word), 32'h1);
        tick();
        check("after_clr_cnt", 32'(o_Err_Count), 32'h2);
        check("after_clr_lock", 32'(o_Locked), 32'h1);

        // Reset mid-stream with clear and errors pending
        rst  = 1'b1;
        flip = 8'h01;
        clr  = 1'b1;
        tick();
        check_all_zero("midrst");
        rst  = 1'b0;
        flip = 8'h00;
        clr  = 1'b0;
        loop = 1'b0;

        // Wrap: seed 1, 127 words back to the seed, word 128 repeats word 1
        en   = 1'b1;
        sdv  = 1'b1;
        seed = 7'h01;
        tick();
        sdv = 1'b0;
        check("wrap_seed_valid", 32'(o_Data_Valid), 32'h0);
        mst = 7'h01;
        for (int k = 1; k <= 128; k++) begin
            tick();
            mres = model_word(mst);
            mst  = mres[14:8];
            check($sformatf("wrap_word%0d", k), 32'(o_Data), 32'(mres[7:0]));
            check($sformatf("wrap_pulse%0d", k), 32'(o_Wrap), (k == 127) ? 32'h1 : 32'h0);
        end
        check("wrap_repeat", 32'(o_Data), 32'hFB);
        en = 1'b0;
        tick();
        check("idle_valid", 32'(o_Data_Valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
